// File: rtl/uart_rx.sv
// 8N1 asynchronous serial receiver with a level-valid / read-acknowledge byte interface.
// Flags framing errors (one-cycle pulse) and overruns (sticky until the byte is read).
module uart_rx (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic [15:0] clock_divider_i,
    input  logic        serial_i,
    input  logic        read_i,
    output logic [7:0]  data_o,
    output logic        valid_o,
    output logic        frame_error_o,
    output logic        overrun_o,
    output logic        busy_o
);

    typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StWaitHigh} state_e;

    state_e      state_q;
    logic        s1_q, s2_q;
    logic [15:0] cnt_q;
    logic [15:0] plim_q;   // P - 1
    logic [15:0] hlim_q;   // H - 1
    logic [2:0]  bit_q;
    logic [7:0]  shift_q;

    logic [15:0] div_clamped;
    logic [15:0] hlim_w;

    // H - 1 = ((div + 1) >> 1) - 1, rearranged so no intermediate exceeds 16 bits.
    always_comb begin
        div_clamped = (clock_divider_i < 16'd2) ? 16'd2 : clock_divider_i;
        hlim_w      = (div_clamped >> 1) + {15'd0, div_clamped[0]} - 16'd1;
    end

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            s1_q <= 1'b1;
            s2_q <= 1'b1;
        end else begin
            s1_q <= serial_i;
            s2_q <= s1_q;
        end
    end

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q       <= StIdle;
            cnt_q         <= 16'd0;
            plim_q        <= 16'd2;
            hlim_q        <= 16'd0;
            bit_q         <= 3'd0;
            shift_q       <= 8'h00;
            data_o        <= 8'h00;
            valid_o       <= 1'b0;
            frame_error_o <= 1'b0;
            overrun_o     <= 1'b0;
            busy_o        <= 1'b0;
        end else begin
            frame_error_o <= 1'b0;
            if (read_i && valid_o) begin
                valid_o   <= 1'b0;
                overrun_o <= 1'b0;
            end

            unique case (state_q)
                StIdle: begin
                    cnt_q <= 16'd0;
                    if (!s2_q) begin
                        state_q <= StStart;
                        busy_o  <= 1'b1;
                        plim_q  <= div_clamped;
                        hlim_q  <= hlim_w;
                    end
                end

                StStart: begin
                    if (cnt_q == hlim_q) begin
                        cnt_q <= 16'd0;
                        bit_q <= 3'd0;
                        if (s2_q) begin
                            state_q <= StIdle;
                            busy_o  <= 1'b0;
                        end else begin
                            state_q <= StData;
                        end
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end

                StData: begin
                    if (cnt_q == plim_q) begin
                        cnt_q   <= 16'd0;
                        shift_q <= {s2_q, shift_q[7:1]};
                        bit_q   <= bit_q + 3'd1;
                        if (bit_q == 3'd7) begin
                            state_q <= StStop;
                        end
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end

                StStop: begin
                    if (cnt_q == plim_q) begin
                        cnt_q <= 16'd0;
                        if (s2_q) begin
                            state_q <= StIdle;
                            busy_o  <= 1'b0;
                            // A read in the completion cycle frees the slot for the new byte.
                            if (!valid_o || read_i) begin
                                data_o    <= shift_q;
                                valid_o   <= 1'b1;
                                overrun_o <= overrun_o & ~read_i;
                            end else begin
                                overrun_o <= 1'b1;
                            end
                        end else begin
                            frame_error_o <= 1'b1;
                            state_q       <= StWaitHigh;
                        end
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end

                StWaitHigh: begin
                    if (s2_q) begin
                        state_q <= StIdle;
                        busy_o  <= 1'b0;
                    end
                end

                default: begin
                    state_q <= StIdle;
                    busy_o  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Randomized and directed bench for uart_rx against a byte-level reference model.
// A bit-serial driver plays the transmitter; expected timing comes from frame arithmetic.
module tb_uart_rx;

    logic        clk;
    logic        rst_n;
    logic [15:0] div;
    logic        serial;
    logic        rd;
    logic [7:0]  data;
    logic        valid;
    logic        fe;
    logic        ov;
    logic        busy;

    uart_rx dut (
        .clock_i        (clk),
        .reset_i        (rst_n),
        .clock_divider_i(div),
        .serial_i       (serial),
        .read_i         (rd),
        .data_o         (data),
        .valid_o        (valid),
        .frame_error_o  (fe),
        .overrun_o      (ov),
        .busy_o         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int frame_cyc = 0;
    int rise_cyc = -1;
    int rise_cnt = 0;
    int fe_cyc = -1;
    int fe_cnt = 0;
    logic valid_prev = 1'b0;

    // Reference model state: the byte held for the reader and the sticky overrun flag.
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ov;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (valid && !valid_prev) begin
            rise_cyc = cyc;
            rise_cnt = rise_cnt + 1;
        end
        valid_prev = valid;
        if (fe) begin
            fe_cyc = cyc;
            fe_cnt = fe_cnt + 1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int bit_period(input int d);
        return ((d < 2) ? 2 : d) + 1;
    endfunction

    // Cycle in which valid/frame_error first shows: detect 2 cycles after the fall,
    // then half a bit to the start-bit centre, then nine whole bits, plus the register.
    function automatic int exp_done(input int c, input int d);
        int p;
        p = bit_period(d);
        return c + 2 + p / 2 + 9 * p + 1;
    endfunction

    task automatic model_frame(input logic [7:0] b, input bit good, input bit rd_same);
        if (good) begin
            if (!m_valid || rd_same) begin
                m_data  = b;
                m_valid = 1'b1;
                if (rd_same) m_ov = 1'b0;
            end else begin
                m_ov = 1'b1;
            end
        end else if (rd_same && m_valid) begin
            m_valid = 1'b0;
            m_ov    = 1'b0;
        end
    endtask

    task automatic model_read();
        if (m_valid) begin
            m_valid = 1'b0;
            m_ov    = 1'b0;
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, "_data"}, data, m_data);
        check({tag, "_valid"}, valid, m_valid);
        check({tag, "_ovr"}, ov, m_ov);
    endtask

    // Called at posedge+1; the line changes in the current cycle.
    task automatic send_frame(input logic [7:0] b, input logic stop, input int p);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        frame_cyc = cyc;
        for (int i = 0; i < 10; i++) begin
            serial = f[i];
            repeat (p) step();
        end
    endtask

    task automatic frame_settle(input logic [7:0] b, input logic stop, input int p);
        send_frame(b, stop, p);
        serial = 1'b1;
        repeat (p + 6) step();
    endtask

    task automatic do_read();
        rd = 1'b1;
        step();
        rd = 1'b0;
    endtask

    logic [7:0] b2b [2];
    logic [7:0] rb;
    int         rdiv;
    int         rp;
    int         c0;
    int         rc0;
    int         fe0;
    int         w;
    bit         good;
    bit         rdf;
    bit         pre_valid;

    initial begin
        b2b[0]  = 8'hA3;
        b2b[1]  = 8'h0F;
        m_data  = 8'h00;
        m_valid = 1'b0;
        m_ov    = 1'b0;
        serial  = 1'b1;
        rd      = 1'b0;
        div     = 16'd9;
        rst_n   = 1'b0;

        // Reset values
        repeat (2) step();
        @(negedge clk);
        check("rst_data", data, 8'h00);
        check("rst_valid", valid, 1'b0);
        check("rst_fe", fe, 1'b0);
        check("rst_ovr", ov, 1'b0);
        check("rst_busy", busy, 1'b0);
        step();
        rst_n = 1'b1;
        repeat (3) step();

        // Good byte, exact latency, then read
        frame_settle(8'h55, 1'b1, 10);
        model_frame(8'h55, 1'b1, 1'b0);
        @(negedge clk);
        check("good_rise", rise_cyc, frame_cyc + 98);
        check_model("good");
        check("good_fe", fe_cnt, 0);
        step();
        do_read();
        model_read();
        @(negedge clk);
        check("good_read_valid", valid, 1'b0);
        step();

        // Back-to-back frames with a reader running alongside
        fork
            begin
                send_frame(b2b[0], 1'b1, 10);
                send_frame(b2b[1], 1'b1, 10);
                serial = 1'b1;
                repeat (20) step();
            end
            begin
                for (int k = 0; k < 2; k++) begin
                    w = 0;
                    while (!valid && w < 400) begin
                        @(negedge clk);
                        w++;
                    end
                    model_frame(b2b[k], 1'b1, 1'b0);
                    check("b2b_valid", valid, 1'b1);
                    check("b2b_data", data, b2b[k]);
                    check("b2b_ovr", ov, 1'b0);
                    step();
                    do_read();
                    model_read();
                end
            end
        join
        @(negedge clk);
        check_model("b2b_end");
        step();

        // Overrun, then read clears both flags
        frame_settle(8'h11, 1'b1, 10);
        model_frame(8'h11, 1'b1, 1'b0);
        frame_settle(8'h22, 1'b1, 10);
        model_frame(8'h22, 1'b1, 1'b0);
        @(negedge clk);
        check_model("ovr");
        step();
        do_read();
        model_read();
        @(negedge clk);
        check_model("ovr_read");
        step();

        // Read in the exact completion cycle of a new byte while an overrun is pending
        frame_settle(8'h44, 1'b1, 10);
        model_frame(8'h44, 1'b1, 1'b0);
        frame_settle(8'h66, 1'b1, 10);
        model_frame(8'h66, 1'b1, 1'b0);
        c0 = cyc;
        fork
            send_frame(8'h33, 1'b1, 10);
            begin
                while (cyc < exp_done(c0, 10'd9) - 1) step();
                do_read();
            end
        join
        serial = 1'b1;
        model_frame(8'h33, 1'b1, 1'b1);
        repeat (5) step();
        @(negedge clk);
        check_model("simul");
        step();
        do_read();
        model_read();

        // Framing error followed by a 50-cycle break
        rc0 = rise_cnt;
        fe0 = fe_cnt;
        send_frame(8'h7E, 1'b0, 10);
        repeat (49) step();
        @(negedge clk);
        check("brk_busy_low", busy, 1'b1);
        step();
        serial = 1'b1;
        repeat (10) step();
        model_frame(8'h7E, 1'b0, 1'b0);
        @(negedge clk);
        check("brk_fe_cnt", fe_cnt, fe0 + 1);
        check("brk_fe_cyc", fe_cyc, exp_done(frame_cyc, 9));
        check("brk_busy_idle", busy, 1'b0);
        check("brk_no_byte", rise_cnt, rc0);
        check_model("brk");
        step();

        // False start: 3-cycle glitch
        rc0 = rise_cnt;
        fe0 = fe_cnt;
        serial = 1'b0;
        repeat (3) step();
        serial = 1'b1;
        @(negedge clk);
        check("glitch_busy", busy, 1'b1);
        repeat (10) step();
        @(negedge clk);
        check("glitch_idle", busy, 1'b0);
        check("glitch_no_byte", rise_cnt, rc0);
        check("glitch_no_fe", fe_cnt, fe0);
        step();

        // Divider 0 behaves as P = 3
        div = 16'd0;
        frame_settle(8'hC9, 1'b1, 3);
        model_frame(8'hC9, 1'b1, 1'b0);
        @(negedge clk);
        check("div0_rise", rise_cyc, exp_done(frame_cyc, 0));
        check_model("div0");
        step();
        do_read();
        model_read();

        // Reset during data bit 4
        div = 16'd9;
        c0 = cyc;
        fork
            begin
                send_frame(8'hFF, 1'b1, 10);
                serial = 1'b1;
            end
            begin
                while (cyc < c0 + 55) step();
                #2;
                rst_n = 1'b0;
                #1;
                m_data  = 8'h00;
                m_valid = 1'b0;
                m_ov    = 1'b0;
                check("mid_rst_busy", busy, 1'b0);
                check("mid_rst_fe", fe, 1'b0);
                check_model("mid_rst");
                repeat (3) step();
                rst_n = 1'b1;
            end
        join
        repeat (5) step();
        frame_settle(8'h5A, 1'b1, 10);
        model_frame(8'h5A, 1'b1, 1'b0);
        @(negedge clk);
        check("post_rst_rise", rise_cyc, exp_done(frame_cyc, 9));
        check_model("post_rst");
        step();
        do_read();
        model_read();

        // Randomized frames: divider, byte, stop-bit quality and read policy
        for (int i = 0; i < 16; i++) begin
            rdiv = $urandom_range(0, 12);
            rp   = bit_period(rdiv);
            rb   = 8'($urandom);
            good = ($urandom_range(0, 4) != 0);
            rdf  = ($urandom_range(0, 1) != 0);
            div  = 16'(rdiv);
            pre_valid = m_valid;
            fe0  = fe_cnt;
            step();
            frame_settle(rb, good, rp);
            model_frame(rb, good, 1'b0);
            @(negedge clk);
            check_model("rnd");
            if (good) begin
                check("rnd_no_fe", fe_cnt, fe0);
                if (!pre_valid) check("rnd_rise", rise_cyc, exp_done(frame_cyc, rdiv));
            end else begin
                check("rnd_fe_cnt", fe_cnt, fe0 + 1);
                check("rnd_fe_cyc", fe_cyc, exp_done(frame_cyc, rdiv));
            end
            check("rnd_busy", busy, 1'b0);
            step();
            if (rdf) begin
                do_read();
                model_read();
                @(negedge clk);
                check_model("rnd_read");
                step();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
